// File: rtl/tiny_rv_regread_pkg.sv
// -----------------------------------------------------------------------------
// tiny_rv_regread_pkg
// Shared definitions for the tiny_rv register-read stage:
//   - RV32I major opcode constants
//   - bubble opcode (an all-zero rr_* bundle reads as a bubble)
//   - immediate-format enum plus the opcode -> format mapping
//   - the packed rr_* pipeline-register bundle
// -----------------------------------------------------------------------------
package tiny_rv_regread_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Opcode value carried by an empty slot.
  localparam logic [6:0] OPC_BUBBLE = 7'h00;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm32;
  } rr_bundle_t;

  // All-zero bundle: opcode field equals OPC_BUBBLE.
  localparam rr_bundle_t RR_BUBBLE = '{default: 1'b0};

  // Map a major opcode to the immediate layout it uses. FENCE and OP carry
  // no immediate that execute consumes, so they fall into FMT_NONE.
  function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: fmt = FMT_I;
      OPC_STORE:                                  fmt = FMT_S;
      OPC_BRANCH:                                 fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:                         fmt = FMT_U;
      OPC_JAL:                                    fmt = FMT_J;
      OPC_OP, OPC_FENCE:                          fmt = FMT_NONE;
      default:                                    fmt = FMT_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/tiny_rv_regfile.sv
// -----------------------------------------------------------------------------
// tiny_rv_regfile
// 32 x 32 architectural register file, two asynchronous read ports and one
// synchronous write port. x0 always reads zero and is never written. The
// asynchronous active-low reset clears every entry.
// Ports:
//   i_clk, i_reset_n       clock / async active-low reset
//   i_we, i_waddr, i_wdata write port (sampled on rising edge)
//   i_raddr_a, o_rdata_a   read port A (combinational)
//   i_raddr_b, o_rdata_b   read port B (combinational)
// -----------------------------------------------------------------------------
module tiny_rv_regfile (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr_a,
  output logic [31:0] o_rdata_a,
  input  logic [4:0]  i_raddr_b,
  output logic [31:0] o_rdata_b
);

  logic [31:0] mem_q [32];
  logic [31:0] mem_d [32];

  // Next-state of the storage array: a single entry updated on a write.
  always_comb begin
    mem_d = mem_q;
    if (i_we && (i_waddr != 5'd0)) begin
      mem_d[i_waddr] = i_wdata;
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage flops with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Asynchronous read ports; x0 is forced to zero regardless of storage.
  always_comb begin
    if (i_raddr_a == 5'd0) begin
      o_rdata_a = 32'd0;
    end else begin
      o_rdata_a = mem_q[i_raddr_a];
    end
    if (i_raddr_b == 5'd0) begin
      o_rdata_b = 32'd0;
    end else begin
      o_rdata_b = mem_q[i_raddr_b];
    end
  end

endmodule

// File: rtl/tiny_rv_regread.sv
// -----------------------------------------------------------------------------
// tiny_rv_regread
// Register-read stage of the tiny_rv core. Decodes the fetched instruction
// combinationally, reads both source operands (with bypass from execute's
// in-flight result and its writeback), and captures everything into the
// registered rr_* bundle that feeds execute.
// Ports:
//   i_clk, i_reset_n          clock / async active-low reset
//   if_valid, if_pc, if_inst  fetched instruction slot
//   rr_if_stall               back-pressure to fetch (mirrors exec_rr_stall)
//   exec_rr_stall             execute cannot accept: hold rr_*
//   exec_rr_flush             redirect: load a bubble (wins over stall)
//   of1_reg, of1_val          rd / combinational result of the op in execute
//   exec_rd, exec_rd_val      writeback port (also a bypass source)
//   rr_*                      registered decoded bundle
// -----------------------------------------------------------------------------
module tiny_rv_regread
  import tiny_rv_regread_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  output logic        rr_if_stall,
  input  logic        exec_rr_stall,
  input  logic        exec_rr_flush,
  input  logic [4:0]  of1_reg,
  input  logic [31:0] of1_val,
  input  logic [4:0]  exec_rd,
  input  logic [31:0] exec_rd_val,
  output logic [31:0] rr_pc,
  output logic [31:0] rr_inst,
  output logic [6:0]  rr_opcode,
  output logic [4:0]  rr_rd,
  output logic [2:0]  rr_funct3,
  output logic [6:0]  rr_funct7,
  output logic [31:0] rr_rs1,
  output logic [31:0] rr_rs2,
  output logic [31:0] rr_imm32
);

  // Bypass priority: x0, then the op in execute (youngest), then writeback
  // (one older), then the architectural file.
  function automatic logic [31:0] operand_sel(
    input logic [4:0]  idx,
    input logic [4:0]  fwd1_reg,
    input logic [31:0] fwd1_val,
    input logic [4:0]  wb_reg,
    input logic [31:0] wb_val,
    input logic [31:0] rf_val
  );
    logic [31:0] val;
    if (idx == 5'd0) begin
      val = 32'd0;
    end else if (idx == fwd1_reg) begin
      val = fwd1_val;
    end else if (idx == wb_reg) begin
      val = wb_val;
    end else begin
      val = rf_val;
    end
    return val;
  endfunction

  logic [4:0]  dec_rs1_idx;
  logic [4:0]  dec_rs2_idx;
  imm_fmt_e    dec_fmt;
  logic [31:0] dec_imm;
  logic [31:0] rf_rdata_a;
  logic [31:0] rf_rdata_b;
  logic [31:0] dec_rs1_val;
  logic [31:0] dec_rs2_val;
  logic        rf_we;
  rr_bundle_t  dec_bundle;
  rr_bundle_t  rr_d;
  rr_bundle_t  rr_q;

  assign dec_rs1_idx = if_inst[19:15];
  assign dec_rs2_idx = if_inst[24:20];
  assign dec_fmt     = imm_fmt_of(if_inst[6:0]);
  assign rf_we       = (exec_rd != 5'd0);

  // Fetch only needs to know about stall; flush reaches it via execute's
  // PC redirect instead.
  assign rr_if_stall = exec_rr_stall;

  tiny_rv_regfile u_regfile (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_we      (rf_we),
    .i_waddr   (exec_rd),
    .i_wdata   (exec_rd_val),
    .i_raddr_a (dec_rs1_idx),
    .o_rdata_a (rf_rdata_a),
    .i_raddr_b (dec_rs2_idx),
    .o_rdata_b (rf_rdata_b)
  );

  // Immediate assembly for the decoded format, sign-extended from inst[31].
  always_comb begin
    dec_imm = 32'd0;
    case (dec_fmt)
      FMT_I: dec_imm = {{20{if_inst[31]}}, if_inst[31:20]};
      FMT_S: dec_imm = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
      FMT_B: dec_imm = {{19{if_inst[31]}}, if_inst[31], if_inst[7],
                        if_inst[30:25], if_inst[11:8], 1'b0};
      FMT_U: dec_imm = {if_inst[31:12], 12'd0};
      FMT_J: dec_imm = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12],
                        if_inst[20], if_inst[30:21], 1'b0};
      FMT_NONE: dec_imm = 32'd0;
      default:  dec_imm = 32'd0;
    endcase
  end

  // Operand muxes; both fields are read whatever the instruction format.
  always_comb begin
    dec_rs1_val = operand_sel(dec_rs1_idx, of1_reg, of1_val,
                              exec_rd, exec_rd_val, rf_rdata_a);
    dec_rs2_val = operand_sel(dec_rs2_idx, of1_reg, of1_val,
                              exec_rd, exec_rd_val, rf_rdata_b);
  end

  // Assemble the decode slot into bundle form.
  always_comb begin
    dec_bundle        = RR_BUBBLE;
    dec_bundle.pc     = if_pc;
    dec_bundle.inst   = if_inst;
    dec_bundle.opcode = if_inst[6:0];
    dec_bundle.rd     = if_inst[11:7];
    dec_bundle.funct3 = if_inst[14:12];
    dec_bundle.funct7 = if_inst[31:25];
    dec_bundle.rs1    = dec_rs1_val;
    dec_bundle.rs2    = dec_rs2_val;
    dec_bundle.imm32  = dec_imm;
  end

  // Load control: flush beats stall; a stalled slot keeps its operands
  // unrefreshed and recaptures bypass values on the unstall edge.
  always_comb begin
    rr_d = rr_q;
    if (exec_rr_flush) begin
      rr_d = RR_BUBBLE;
    end else if (exec_rr_stall) begin
      rr_d = rr_q;
    end else if (!if_valid) begin
      rr_d = RR_BUBBLE;
    end else begin
      rr_d = dec_bundle;
    end
  end

  // rr_* pipeline register, cleared immediately by reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rr_q <= RR_BUBBLE;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign rr_pc     = rr_q.pc;
  assign rr_inst   = rr_q.inst;
  assign rr_opcode = rr_q.opcode;
  assign rr_rd     = rr_q.rd;
  assign rr_funct3 = rr_q.funct3;
  assign rr_funct7 = rr_q.funct7;
  assign rr_rs1    = rr_q.rs1;
  assign rr_rs2    = rr_q.rs2;
  assign rr_imm32  = rr_q.imm32;

endmodule

// File: tb/tb_tiny_rv_regread.sv
// -----------------------------------------------------------------------------
// tb_tiny_rv_regread
// Scoreboard bench: each driven slot pushes its expected rr_* bundle, and the
// bundle is popped and compared one clock later when the DUT presents it.
// -----------------------------------------------------------------------------
module tb_tiny_rv_regread;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_pc = 32'd0;
  logic [31:0] if_inst = 32'd0;
  logic        rr_if_stall;
  logic        exec_rr_stall = 1'b0;
  logic        exec_rr_flush = 1'b0;
  logic [4:0]  of1_reg = 5'd0;
  logic [31:0] of1_val = 32'd0;
  logic [4:0]  exec_rd = 5'd0;
  logic [31:0] exec_rd_val = 32'd0;
  logic [31:0] rr_pc, rr_inst, rr_rs1, rr_rs2, rr_imm32;
  logic [6:0]  rr_opcode, rr_funct7;
  logic [4:0]  rr_rd;
  logic [2:0]  rr_funct3;

  int checks = 0;
  int errors = 0;

  logic [181:0] exp_q[$];
  logic [181:0] obs;
  logic [181:0] expv;

  tiny_rv_regread dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .rr_if_stall(rr_if_stall),
    .exec_rr_stall(exec_rr_stall), .exec_rr_flush(exec_rr_flush),
    .of1_reg(of1_reg), .of1_val(of1_val),
    .exec_rd(exec_rd), .exec_rd_val(exec_rd_val),
    .rr_pc(rr_pc), .rr_inst(rr_inst), .rr_opcode(rr_opcode), .rr_rd(rr_rd),
    .rr_funct3(rr_funct3), .rr_funct7(rr_funct7),
    .rr_rs1(rr_rs1), .rr_rs2(rr_rs2), .rr_imm32(rr_imm32)
  );

  always #5 i_clk = ~i_clk;

  assign obs = {rr_pc, rr_inst, rr_opcode, rr_rd, rr_funct3, rr_funct7,
                rr_rs1, rr_rs2, rr_imm32};

  function automatic logic [181:0] bundle(input logic [31:0] pc,
                                          input logic [31:0] inst,
                                          input logic [31:0] rs1,
                                          input logic [31:0] rs2,
                                          input logic [31:0] imm);
    return {pc, inst, inst[6:0], inst[11:7], inst[14:12], inst[31:25],
            rs1, rs2, imm};
  endfunction

  function automatic logic [31:0] r_type(input logic [4:0] rs1,
                                         input logic [4:0] rs2,
                                         input logic [4:0] rd);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
  endfunction

  task automatic cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
  endtask

  task automatic test_reset();
    logic [31:0] inst;
    i_reset_n = 1'b0;
    cycle();
    cycle();
    checks++;
    if (obs !== 182'd0) begin
      errors++;
      $display("FAIL reset_state: got %h want 0", obs);
    end
    i_reset_n = 1'b1;
    // Write x3 and load a live slot so the mid-stream reset has work to undo.
    exec_rd = 5'd3; exec_rd_val = 32'h0000_0033;
    drive(1'b1, 32'h40, 32'hFFF00293);
    cycle();
    exec_rd = 5'd0; exec_rd_val = 32'd0;
    drive(1'b0, 32'd0, 32'd0);
    #2;
    i_reset_n = 1'b0;
    exec_rr_stall = 1'b1;
    #1;
    checks++;
    if (obs !== 182'd0) begin
      errors++;
      $display("FAIL reset_async: got %h want 0", obs);
    end
    checks++;
    if (rr_if_stall !== 1'b1) begin
      errors++;
      $display("FAIL reset_if_stall: got %b want 1", rr_if_stall);
    end
    exec_rr_stall = 1'b0;
    exp_q.delete();
    cycle();
    cycle();
    i_reset_n = 1'b1;
    for (int i = 1; i < 32; i++) begin
      inst = r_type(i[4:0], i[4:0], 5'd0);
      drive(1'b1, 32'(i * 4), inst);
      exp_q.push_back(bundle(32'(i * 4), inst, 32'd0, 32'd0, 32'd0));
      cycle();
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL reset_regs x%0d: got %h want %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_decode();
    drive(1'b1, 32'h100, 32'hFFF00293);
    exp_q.push_back(bundle(32'h100, 32'hFFF00293, 32'd0, 32'd0, 32'hFFFF_FFFF));
    cycle();
    expv = exp_q.pop_front();
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL decode_addi: got %h want %h", obs, expv);
    end
  endtask

  task automatic test_immediates();
    logic [31:0] insts [4];
    logic [31:0] imms  [4];
    insts = '{32'hFE000EE3, 32'h008000EF, 32'h00512623, 32'h123452B7};
    imms  = '{32'hFFFF_FFFC, 32'h0000_0008, 32'h0000_000C, 32'h1234_5000};
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h200 + 32'(k * 4), insts[k]);
      exp_q.push_back(bundle(32'h200 + 32'(k * 4), insts[k], 32'd0, 32'd0, imms[k]));
      cycle();
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL imm_%0d: got %h want %h", k, obs, expv);
      end
    end
  endtask

  task automatic test_bypass();
    logic [4:0]  o_reg [5];
    logic [31:0] o_val [5];
    logic [4:0]  w_reg [5];
    logic [31:0] w_val [5];
    logic [31:0] insts [5];
    logic [31:0] e1 [5];
    logic [31:0] e2 [5];
    logic [31:0] im [5];
    o_reg = '{5'd5, 5'd0, 5'd0, 5'd5, 5'd0};
    o_val = '{32'h1234, 32'h0, 32'h0, 32'h5555, 32'h77};
    w_reg = '{5'd5, 5'd5, 5'd0, 5'd0, 5'd0};
    w_val = '{32'hAAAA, 32'hBBBB, 32'h0, 32'h0, 32'h99};
    insts = '{32'h00528333, 32'h00528333, 32'h00528333, 32'h00528333, 32'hFFF00293};
    e1    = '{32'h1234, 32'hBBBB, 32'hBBBB, 32'h5555, 32'h0};
    e2    = '{32'h1234, 32'hBBBB, 32'hBBBB, 32'h5555, 32'h0};
    im    = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF};
    for (int k = 0; k < 5; k++) begin
      of1_reg = o_reg[k]; of1_val = o_val[k];
      exec_rd = w_reg[k]; exec_rd_val = w_val[k];
      drive(1'b1, 32'h300 + 32'(k * 4), insts[k]);
      exp_q.push_back(bundle(32'h300 + 32'(k * 4), insts[k], e1[k], e2[k], im[k]));
      cycle();
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL bypass_%0d: got %h want %h", k, obs, expv);
      end
    end
    of1_reg = 5'd0; of1_val = 32'd0;
    exec_rd = 5'd0; exec_rd_val = 32'd0;
  endtask

  task automatic test_writeback();
    logic [31:0] inst;
    exec_rd = 5'd7; exec_rd_val = 32'hDEAD_BEEF;
    drive(1'b0, 32'h400, 32'h00528333);
    exp_q.push_back(182'd0);
    cycle();
    expv = exp_q.pop_front();
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL wb_bubble: got %h want %h", obs, expv);
    end
    exec_rd = 5'd0; exec_rd_val = 32'd5;
    cycle();
    exec_rd_val = 32'd0;
    inst = r_type(5'd7, 5'd0, 5'd1);
    drive(1'b1, 32'h408, inst);
    exp_q.push_back(bundle(32'h408, inst, 32'hDEAD_BEEF, 32'd0, 32'd0));
    cycle();
    expv = exp_q.pop_front();
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL wb_read_x7: got %h want %h", obs, expv);
    end
  endtask

  task automatic test_stall_flush();
    logic [31:0] a;
    logic [181:0] a_exp;
    a = r_type(5'd7, 5'd5, 5'd2);
    a_exp = bundle(32'h500, a, 32'hDEAD_BEEF, 32'hBBBB, 32'd0);
    drive(1'b1, 32'h500, a);
    exp_q.push_back(a_exp);
    cycle();
    expv = exp_q.pop_front();
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL stall_load: got %h want %h", obs, expv);
    end
    exec_rr_stall = 1'b1;
    drive(1'b1, 32'h504, 32'hFFF00293);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(a_exp);
      cycle();
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv || rr_if_stall !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold_%0d: got %h stall=%b want %h stall=1",
                 k, obs, rr_if_stall, expv);
      end
    end
    exec_rr_flush = 1'b1;
    exp_q.push_back(182'd0);
    cycle();
    expv = exp_q.pop_front();
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL flush_over_stall: got %h want %h", obs, expv);
    end
    exec_rr_flush = 1'b0;
    exec_rr_stall = 1'b0;
    exp_q.push_back(bundle(32'h504, 32'hFFF00293, 32'd0, 32'd0, 32'hFFFF_FFFF));
    cycle();
    expv = exp_q.pop_front();
    checks++;
    if (obs !== expv || rr_if_stall !== 1'b0) begin
      errors++;
      $display("FAIL unstall_load: got %h stall=%b want %h stall=0",
               obs, rr_if_stall, expv);
    end
    drive(1'b0, 32'h508, 32'h00528333);
    exp_q.push_back(182'd0);
    cycle();
    expv = exp_q.pop_front();
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL invalid_bubble: got %h want %h", obs, expv);
    end
    drive(1'b1, 32'h50C, 32'h00528333);
    exec_rr_flush = 1'b1;
    exp_q.push_back(182'd0);
    cycle();
    expv = exp_q.pop_front();
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL flush_alone: got %h want %h", obs, expv);
    end
    exec_rr_flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] i1, i2, i3;
    logic [181:0] i1_exp;
    i1 = r_type(5'd3, 5'd3, 5'd9);
    i2 = r_type(5'd9, 5'd9, 5'd10);
    i3 = r_type(5'd10, 5'd9, 5'd11);
    i1_exp = bundle(32'h600, i1, 32'd0, 32'd0, 32'd0);
    drive(1'b1, 32'h600, i1);
    exp_q.push_back(i1_exp);
    cycle();
    expv = exp_q.pop_front();
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL b2b_first: got %h want %h", obs, expv);
    end
    // i1 sits in execute while it stalls; i2 depends on its result.
    exec_rr_stall = 1'b1;
    of1_reg = 5'd9; of1_val = 32'h1111;
    drive(1'b1, 32'h604, i2);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(i1_exp);
      cycle();
      of1_val = 32'h2222;
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL b2b_hold_%0d: got %h want %h", k, obs, expv);
      end
    end
    exec_rr_stall = 1'b0;
    of1_val = 32'h3333;
    exp_q.push_back(bundle(32'h604, i2, 32'h3333, 32'h3333, 32'd0));
    cycle();
    expv = exp_q.pop_front();
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL b2b_unstall_capture: got %h want %h", obs, expv);
    end
    // i2 now in execute producing x10; i1's x9 retires via writeback.
    of1_reg = 5'd10; of1_val = 32'h4444;
    exec_rd = 5'd9; exec_rd_val = 32'h3333;
    drive(1'b1, 32'h608, i3);
    exp_q.push_back(bundle(32'h608, i3, 32'h4444, 32'h3333, 32'd0));
    cycle();
    expv = exp_q.pop_front();
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL b2b_chain: got %h want %h", obs, expv);
    end
    of1_reg = 5'd0; of1_val = 32'd0;
    exec_rd = 5'd0; exec_rd_val = 32'd0;
    drive(1'b1, 32'h60C, i3);
    exp_q.push_back(bundle(32'h60C, i3, 32'd0, 32'h3333, 32'd0));
    cycle();
    expv = exp_q.pop_front();
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL b2b_regfile: got %h want %h", obs, expv);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_decode();
    test_immediates();
    test_bypass();
    test_writeback();
    test_stall_flush();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
